// File: rtl/iter_mul_pkg.sv
// Shared types and constants for the iterative shift-add multiplier.
package iter_mul_pkg;
  localparam int W_DEF = 32;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction
endpackage

// File: rtl/iter_mul_if.sv
// Operand/product handshake bundle between the execute stage and iter_mul.
interface iter_mul_if #(parameter int W = 32);
  logic [W-1:0]   x;
  logic [W-1:0]   y;
  logic           in_valid;
  logic           mul_signed;
  logic           in_ready;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] p;

  modport master (
    output x, y, in_valid, mul_signed, out_ready,
    input  in_ready, out_valid, p
  );

  modport slave (
    input  x, y, in_valid, mul_signed, out_ready,
    output in_ready, out_valid, p
  );
endinterface

// File: rtl/iter_mul_neg_2w.sv
// Parameterised two's-complement negator (~a + 1).
module neg_2w #(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  output logic [N-1:0] y_o
);
  assign y_o = ~a_i + N'(1);
endmodule

// File: rtl/iter_mul.sv
// Iterative radix-2 shift-add multiplier, W x W -> 2W, signed or unsigned.
module iter_mul
  import iter_mul_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic   clk,
  input  logic   resetn,
  iter_mul_if.slave bus
);
  localparam int CNT_W = cnt_w(W);

  state_e           state_q, state_d;
  logic [W-1:0]     mcand_q, mplr_q;
  logic [2*W-1:0]   acc_q, p_q;
  logic [CNT_W-1:0] count_q;
  logic             neg_q;

  logic [W-1:0]     x_neg, y_neg, x_mag, y_mag;
  logic [2*W-1:0]   acc_neg;
  logic [W:0]       sum;
  logic             accept, release_o, calc_last;

  neg_2w #(.N(W))   u_neg_x   (.a_i(bus.x), .y_o(x_neg));
  neg_2w #(.N(W))   u_neg_y   (.a_i(bus.y), .y_o(y_neg));
  neg_2w #(.N(2*W)) u_neg_acc (.a_i(acc_q), .y_o(acc_neg));

  // |0x80..0| wraps back to 0x80..0, which is the correct unsigned magnitude.
  assign x_mag = (bus.mul_signed & bus.x[W-1]) ? x_neg : bus.x;
  assign y_mag = (bus.mul_signed & bus.y[W-1]) ? y_neg : bus.y;

  assign sum       = {1'b0, acc_q[2*W-1:W]} + {1'b0, (mplr_q[0] ? mcand_q : '0)};
  assign accept    = (state_q == IDLE) & bus.in_valid;
  assign release_o = (state_q == DONE) & bus.out_ready;
  assign calc_last = (count_q == CNT_W'(W-1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = CALC;
      CALC:    if (calc_last) state_d = FIX;
      FIX:                    state_d = DONE;
      DONE:    if (release_o) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
  end

  assign bus.p = p_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      p_q     <= '0;
      count_q <= '0;
      neg_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          mcand_q <= x_mag;
          mplr_q  <= y_mag;
          neg_q   <= bus.mul_signed & (bus.x[W-1] ^ bus.y[W-1]);
          acc_q   <= '0;
          count_q <= '0;
        end
        CALC: begin
          // Carry-out lands in the top bit; low product bits shift out below.
          acc_q   <= {sum, acc_q[W-1:1]};
          mplr_q  <= mplr_q >> 1;
          count_q <= count_q + CNT_W'(1);
        end
        FIX:     p_q <= neg_q ? acc_neg : acc_q;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_iter_mul.sv
// Directed self-checking bench for iter_mul.
module tb_iter_mul;
  logic clk, resetn;
  int   checks, failures;

  iter_mul_if #(.W(32)) bus ();
  iter_mul #(.W(32)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [63:0] exp);
    int n;
    bus.x = a; bus.y = b; bus.mul_signed = s; bus.in_valid = 1'b1;
    chk({tag, ".rdy"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.x = '0; bus.y = '0; bus.mul_signed = 1'b0;
    chk({tag, ".busy"}, 64'(bus.in_ready), 64'd0);
    wait_out(n);
    chk({tag, ".lat"}, 64'(n), 64'd33);
    chk({tag, ".p"}, bus.p, exp);
    if (bus.out_ready) begin
      @(posedge clk); #1;
      chk({tag, ".ovlo"}, 64'(bus.out_valid), 64'd0);
      chk({tag, ".irhi"}, 64'(bus.in_ready), 64'd1);
    end
  endtask

  logic [31:0] bx [3];
  logic [31:0] by [3];
  logic        bs [3];
  logic [63:0] bp [3];

  initial begin
    int n;
    checks = 0; failures = 0;
    resetn = 1'b0;
    bus.x = '0; bus.y = '0; bus.in_valid = 1'b0; bus.mul_signed = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.ir", 64'(bus.in_ready), 64'd1);
    chk("rst.ov", 64'(bus.out_valid), 64'd0);
    chk("rst.p", bus.p, 64'd0);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;

    run_op("umax",   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001);
    run_op("smix",   32'hFFFFFFFD, 32'd7,        1'b1, 64'hFFFFFFFFFFFFFFEB);
    run_op("umix",   32'hFFFFFFFD, 32'd7,        1'b0, 64'h00000006FFFFFFEB);
    run_op("smin2",  32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000);
    run_op("sminm1", 32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h0000000080000000);
    run_op("zero",   32'd0,        32'h00001234, 1'b1, 64'd0);

    // Backpressure: result must hold while the consumer stalls.
    bus.out_ready = 1'b0;
    run_op("bp", 32'h12345678, 32'h9ABCDEF0, 1'b0, 64'h0B00EA4E242D2080);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp.p",  bus.p, 64'h0B00EA4E242D2080);
      chk("bp.ov", 64'(bus.out_valid), 64'd1);
      chk("bp.ir", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.ovlo", 64'(bus.out_valid), 64'd0);
    chk("bp.irhi", 64'(bus.in_ready), 64'd1);

    // Back-to-back with in_valid held high across three ops.
    bx[0] = 32'h10;       by[0] = 32'h20;       bs[0] = 1'b0; bp[0] = 64'h200;
    bx[1] = 32'hFFFFFFFF; by[1] = 32'hFFFFFFFF; bs[1] = 1'b1; bp[1] = 64'd1;
    bx[2] = 32'hFFFFFFFF; by[2] = 32'd2;        bs[2] = 1'b1; bp[2] = 64'hFFFFFFFFFFFFFFFE;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.x = bx[k]; bus.y = by[k]; bus.mul_signed = bs[k];
      chk($sformatf("b2b%0d.rdy", k), 64'(bus.in_ready), 64'd1);
      @(posedge clk); #1;
      if (k == 2) bus.in_valid = 1'b0;
      chk($sformatf("b2b%0d.busy", k), 64'(bus.in_ready), 64'd0);
      wait_out(n);
      chk($sformatf("b2b%0d.lat", k), 64'(n), 64'd33);
      chk($sformatf("b2b%0d.p", k), bus.p, bp[k]);
      @(posedge clk); #1;
      chk($sformatf("b2b%0d.ovlo", k), 64'(bus.out_valid), 64'd0);
      chk($sformatf("b2b%0d.irhi", k), 64'(bus.in_ready), 64'd1);
    end
    @(posedge clk); #1;
    chk("b2b.nodup", 64'(bus.in_ready), 64'd1);

    // Asynchronous reset in the middle of CALC.
    bus.x = 32'h12345678; bus.y = 32'h9ABCDEF0; bus.mul_signed = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    chk("arst.ir", 64'(bus.in_ready), 64'd1);
    chk("arst.ov", 64'(bus.out_valid), 64'd0);
    chk("arst.p",  bus.p, 64'd0);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    run_op("rst5x6", 32'd5, 32'd6, 1'b0, 64'd30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
